cpu_multicycle: RTL and testbench
=================================

Name: cpu_multicycle

Overview:
- Multicycle successor to the single-cycle core, built as a finite state machine.
- One unified instruction/data memory port with a req/ready handshake, so memory may insert wait states.
- Adds three things the single-cycle core lacks: configurable reset vector, trap on illegal or unaligned accesses, and a retired-instruction counter.
- Sits under mother_board and connects to one memory model.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.
- NREG, 32, number of architectural registers; $0 is hardwired to zero.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- mem_req  output  1  memory transaction request.
- mem_we  output  1  write enable; valid when mem_req=1.
- mem_addr  output  32  byte address; always word-aligned when mem_req=1.
- mem_wdata  output  32  store data.
- mem_rdata  input  32  load/fetch data; valid when mem_ready=1.
- mem_ready  input  1  transaction completes in any cycle with mem_req=1 and mem_ready=1.
- pc  output  32  current PC.
- trap  output  1  sticky fault flag.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset values: state=FETCH, pc=RESET_PC, all registers 0, instret=0, trap=0, mem_we=0. mem_req=1 in the first cycle after reset, because FETCH drives it.
- Instructions supported: lw, sw, beq, addi, j, and R-type add/sub/and/or/slt. Any other opcode or funct goes to TRAP.
- State sequences:
  - All instructions: FETCH -> DECODE.
  - lw/sw: DECODE -> MEMADR. lw then MEMRD -> MEMWB -> FETCH. sw then MEMWR -> FETCH.
  - R-type: DECODE -> EXEC -> ALUWB -> FETCH.
  - addi: DECODE -> ADDIEX -> ADDIWB -> FETCH.
  - beq: DECODE -> BRANCH -> FETCH.
  - j: DECODE -> JUMP -> FETCH.
- Memory states (FETCH, MEMRD, MEMWR):
  - Drive mem_req=1. Hold mem_addr, mem_we and mem_wdata stable until mem_ready.
  - Stay in the state while mem_ready=0.
  - The instruction register and the data register capture mem_rdata only on the handshake cycle.
- mem_req=0 in all other states.
- Zero-wait cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle adds one.
- PC update:
  - FETCH handshake: pc <= pc+4.
  - BRANCH: if rs==rt, pc <= pc + (sext(imm)<<2), computed from the already-incremented pc.
  - JUMP: pc <= {pc[31:28], addr26, 2'b00}.
- Arithmetic:
  - All operations are 32-bit and wrap modulo 2^32; there is no overflow exception.
  - slt is a signed compare with a zero-extended 1-bit result.
  - addi uses a sign-extended immediate.
- Writes to $0 are discarded; reads of $0 return 0.
- Alignment: in MEMADR, an effective address with addr[1:0] != 0 goes to TRAP; no memory request is issued.
- TRAP state:
  - trap=1, mem_req=0.
  - pc frozen at the faulting instruction's pc+4.
  - Exits only on reset.
  - instret does not count the faulting instruction.
- instret increments by 1 on entry to FETCH from any completing state (MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP). It wraps at 2^CNT_W.
- Reset mid-transaction: at the next edge the state returns to FETCH at RESET_PC. The pending request is abandoned; the memory model must tolerate this.
- Simultaneous reset and mem_ready: reset wins and no state is captured.

Decomposition:
- Package lib_cpu:
  - OPECODE and FUNCT enums, extended with ADDI and J.
  - STATE enum.
  - ALU_CTRL 3-bit enum.
  - RESET-independent constants: REG_ZERO, OP_WIDTH=6.
- Sub-module regfile:
  - Parameter NREG.
  - Two combinational read ports, one synchronous write port.
  - Synchronous reset clears all registers.
  - $0 hardwired to zero.
- The FSM controller and the datapath stay in cpu_multicycle.

Test Plan:
- Reset with RESET_PC=32'h100 and a zero-wait memory -> first mem_addr=32'h100, mem_req=1. After addi $1,$0,5 -> $1=5 in cycle 4; pc=32'h104; instret=1.
- Program addi $1,$0,-1; addi $2,$0,1; add $3,$1,$2; slt $4,$1,$2 -> $3=0 (wrap), $4=1 (signed compare).
- sw $1,8($0) then lw $5,8($0), with mem_ready low for 3 cycles on every request -> address, write enable and data are stable while waiting; $5=32'hFFFF_FFFF; sw takes 7 cycles and lw takes 8.
- beq taken with imm=-1 at pc=32'h10 -> next fetch at 32'h10 (tight loop). Not taken -> fetch at 32'h14. j 0x40 -> fetch at 32'h100.
- lw $1,2($0) -> no data request; trap=1 and stays set for 20 cycles; instret unchanged. Separately, opcode 6'h3F -> trap=1.
- Assert reset during a 5-cycle stalled fetch -> next cycle state=FETCH, pc=RESET_PC, trap=0, instret=0.

Source files
------------

// File: rtl/cpu_multicycle_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs,
// controller states, ALU controls and the ALU itself.
package lib_cpu;

   localparam int unsigned OP_WIDTH = 6;
   localparam logic [4:0]  REG_ZERO = 5'd0;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_BEQ   = 6'h04,
      OP_ADDI  = 6'h08,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opecode_e;

   typedef enum logic [5:0] {
      FN_ADD = 6'h20,
      FN_SUB = 6'h22,
      FN_AND = 6'h24,
      FN_OR  = 6'h25,
      FN_SLT = 6'h2A
   } funct_e;

   typedef enum logic [3:0] {
      ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
      ST_EXEC, ST_ALUWB, ST_ADDIEX, ST_ADDIWB, ST_BRANCH, ST_JUMP, ST_TRAP
   } state_e;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctrl_e;

   function automatic logic funct_valid(input logic [5:0] f);
      case (f)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic alu_ctrl_e funct_to_alu(input logic [5:0] f);
      case (f)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic [31:0] alu(input alu_ctrl_e c, input logic [31:0] a,
                                       input logic [31:0] b);
      case (c)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_SUB: return a - b;
         ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
         default: return a + b;
      endcase
   endfunction

endpackage

// File: rtl/cpu_multicycle_regfile.sv
// Architectural register file: two combinational reads, one synchronous
// write, synchronous clear; register 0 always reads as zero.
module regfile
   import lib_cpu::*;
#(
   parameter int unsigned NREG = 32,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic [AW-1:0] i_raddr1,
   input  logic [AW-1:0] i_raddr2,
   output logic [31:0]   o_rdata1,
   output logic [31:0]   o_rdata2,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata
);

   logic [31:0] r_regs [NREG];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_regs <= '{default: '0};
      end else if (i_we && (i_waddr != AW'(REG_ZERO))) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_raddr1 == AW'(REG_ZERO)) ? '0 : r_regs[i_raddr1];
   assign o_rdata2 = (i_raddr2 == AW'(REG_ZERO)) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle core: FSM controller and datapath sharing one req/ready
// memory port, with trap on illegal/unaligned accesses and retire counter.
module cpu_multicycle
   import lib_cpu::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned NREG     = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ready,
   output logic [31:0]      pc,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   localparam int unsigned RA_W = $clog2(NREG);

   state_e           r_state;
   logic [31:0]      r_pc, r_ir, r_mdr, r_a, r_b, r_alu_out;
   logic [31:0]      r_mem_addr, r_mem_wdata;
   logic             r_mem_req, r_mem_we, r_trap;
   logic [CNT_W-1:0] r_instret;

   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd, w_rf_waddr;
   logic [31:0] w_simm, w_ea, w_fetch_pc, w_rd1, w_rd2, w_rf_wdata;
   logic        w_rf_we;

   assign w_op    = r_ir[31:26];
   assign w_rs    = r_ir[25:21];
   assign w_rt    = r_ir[20:16];
   assign w_rd    = r_ir[15:11];
   assign w_funct = r_ir[5:0];
   assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};
   assign w_ea    = r_a + w_simm;

   assign w_rf_we    = (r_state == ST_MEMWB) || (r_state == ST_ALUWB) ||
                       (r_state == ST_ADDIWB);
   assign w_rf_waddr = (r_state == ST_ALUWB) ? w_rd : w_rt;
   assign w_rf_wdata = (r_state == ST_MEMWB) ? r_mdr : r_alu_out;

   // Address of the next fetch when an instruction completes; r_pc already holds pc+4.
   always_comb begin
      w_fetch_pc = r_pc;
      if (r_state == ST_BRANCH && r_a == r_b) begin
         w_fetch_pc = r_pc + {w_simm[29:0], 2'b00};
      end else if (r_state == ST_JUMP) begin
         w_fetch_pc = {r_pc[31:28], r_ir[25:0], 2'b00};
      end
   end

   regfile #(.NREG(NREG)) u_rf (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_raddr1 (w_rs[RA_W-1:0]),
      .i_raddr2 (w_rt[RA_W-1:0]),
      .o_rdata1 (w_rd1),
      .o_rdata2 (w_rd2),
      .i_we     (w_rf_we),
      .i_waddr  (w_rf_waddr[RA_W-1:0]),
      .i_wdata  (w_rf_wdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_FETCH;
         r_pc        <= RESET_PC;
         r_ir        <= '0;
         r_mdr       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_alu_out   <= '0;
         r_mem_req   <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= RESET_PC;
         r_mem_wdata <= '0;
         r_trap      <= 1'b0;
         r_instret   <= '0;
      end else begin
         case (r_state)
            ST_FETCH: if (mem_ready) begin
               r_ir      <= mem_rdata;
               r_pc      <= r_pc + 32'd4;
               r_mem_req <= 1'b0;
               r_state   <= ST_DECODE;
            end
            ST_DECODE: begin
               r_a <= w_rd1;
               r_b <= w_rd2;
               case (w_op)
                  OP_LW, OP_SW: r_state <= ST_MEMADR;
                  OP_ADDI:      r_state <= ST_ADDIEX;
                  OP_BEQ:       r_state <= ST_BRANCH;
                  OP_J:         r_state <= ST_JUMP;
                  OP_RTYPE: begin
                     if (funct_valid(w_funct)) begin
                        r_state <= ST_EXEC;
                     end else begin
                        r_state <= ST_TRAP;
                        r_trap  <= 1'b1;
                     end
                  end
                  default: begin
                     r_state <= ST_TRAP;
                     r_trap  <= 1'b1;
                  end
               endcase
            end
            ST_MEMADR: begin
               if (w_ea[1:0] != 2'b00) begin
                  r_state <= ST_TRAP;
                  r_trap  <= 1'b1;
               end else begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= (w_op == OP_SW);
                  r_mem_addr  <= w_ea;
                  r_mem_wdata <= r_b;
                  if (w_op == OP_SW) r_state <= ST_MEMWR;
                  else               r_state <= ST_MEMRD;
               end
            end
            ST_MEMRD: if (mem_ready) begin
               r_mdr     <= mem_rdata;
               r_mem_req <= 1'b0;
               r_state   <= ST_MEMWB;
            end
            ST_EXEC: begin
               r_alu_out <= alu(funct_to_alu(w_funct), r_a, r_b);
               r_state   <= ST_ALUWB;
            end
            ST_ADDIEX: begin
               r_alu_out <= r_a + w_simm;
               r_state   <= ST_ADDIWB;
            end
            // Every completing state funnels back into FETCH through one path.
            ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP, ST_MEMWR: begin
               if (r_state != ST_MEMWR || mem_ready) begin
                  r_pc       <= w_fetch_pc;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= w_fetch_pc;
                  r_instret  <= r_instret + 1'b1;
                  r_state    <= ST_FETCH;
               end
            end
            ST_TRAP: r_mem_req <= 1'b0;
            default: begin
               r_state   <= ST_TRAP;
               r_trap    <= 1'b1;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign pc        = r_pc;
   assign trap      = r_trap;
   assign instret   = r_instret;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: ALU vector table plus hand sequences
// for memory wait states, branches/jumps, traps and reset corner cases.
module tb_cpu_multicycle;
   import lib_cpu::*;

   logic        clk, reset;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
   logic        trap;
   logic [31:0] instret;

   cpu_multicycle #(.RESET_PC(32'h100), .CNT_W(32), .NREG(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc        (pc),
      .trap      (trap),
      .instret   (instret)
   );

   typedef struct {
      int          start;
      int          hs;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } xact_t;

   typedef struct {
      logic [5:0]  funct;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] res;
      logic        tr;
   } alu_vec_t;

   logic [31:0] img [1024];
   logic [31:0] mem [1024];
   xact_t       log_q[$];
   int          wait_n, wcnt, cyc, req_start;
   int          n_tests, n_fail;
   logic        stab_en, p_stall, p_we;
   logic [31:0] p_addr, p_wdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: image copied in during reset, req/ready with wait_n stall cycles.
   assign mem_ready = mem_req && (wcnt >= wait_n);
   assign mem_rdata = mem[mem_addr[11:2]];

   always @(posedge clk) begin : mem_model
      xact_t t;
      if (reset) begin
         mem  <= img;
         wcnt <= 0;
      end else if (mem_req && mem_ready) begin
         t.start = (wcnt == 0) ? cyc : req_start;
         t.hs    = cyc;
         t.addr  = mem_addr;
         t.we    = mem_we;
         t.wdata = mem_wdata;
         log_q.push_back(t);
         if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
         wcnt <= 0;
      end else if (mem_req) begin
         if (wcnt == 0) req_start <= cyc;
         wcnt <= wcnt + 1;
      end
      cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Request signals must not change while a request is stalled.
   always @(negedge clk) begin
      if (stab_en && p_stall) begin
         chk("hold_addr", {32'b0, mem_addr}, {32'b0, p_addr});
         chk("hold_we_wdata", {31'b0, mem_we, mem_wdata}, {31'b0, p_we, p_wdata});
      end
      p_stall <= stab_en && mem_req && !mem_ready;
      p_addr  <= mem_addr;
      p_we    <= mem_we;
      p_wdata <= mem_wdata;
   end

   function automatic xact_t getx(input int i);
      xact_t t;
      t = '{default: 0};
      if (i < log_q.size()) t = log_q[i];
      return t;
   endfunction

   function automatic logic [31:0] f_addi(input logic [4:0] rt, input logic [4:0] rs,
                                          input logic [15:0] imm);
      return {6'h08, rs, rt, imm};
   endfunction
   function automatic logic [31:0] f_r(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction
   function automatic logic [31:0] f_mem(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] base, input logic [15:0] imm);
      return {op, base, rt, imm};
   endfunction
   function automatic logic [31:0] f_beq(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
      return {6'h04, rs, rt, imm};
   endfunction
   function automatic logic [31:0] f_j(input logic [25:0] target);
      return {6'h02, target};
   endfunction

   task automatic clr_img();
      for (int i = 0; i < 1024; i++) img[i] = '0;
   endtask
   task automatic put(input logic [31:0] addr, input logic [31:0] word);
      img[addr[11:2]] = word;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      log_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   alu_vec_t vecs[11];
   int       bad;

   initial begin
      reset = 1'b1; wait_n = 0; stab_en = 1'b0; n_tests = 0; n_fail = 0; cyc = 0;
      req_start = 0;

      vecs[0]  = '{6'h20, 16'hFFFF, 16'h0001, 32'h0000_0000, 1'b0};
      vecs[1]  = '{6'h22, 16'h0005, 16'h0007, 32'hFFFF_FFFE, 1'b0};
      vecs[2]  = '{6'h24, 16'hFFFF, 16'h1234, 32'h0000_1234, 1'b0};
      vecs[3]  = '{6'h25, 16'h0F00, 16'h00F0, 32'h0000_0FF0, 1'b0};
      vecs[4]  = '{6'h2A, 16'hFFFF, 16'h0001, 32'h0000_0001, 1'b0};
      vecs[5]  = '{6'h2A, 16'h0001, 16'hFFFF, 32'h0000_0000, 1'b0};
      vecs[6]  = '{6'h2A, 16'h0005, 16'h0005, 32'h0000_0000, 1'b0};
      vecs[7]  = '{6'h20, 16'h7FFF, 16'h7FFF, 32'h0000_FFFE, 1'b0};
      vecs[8]  = '{6'h22, 16'h0000, 16'h0001, 32'hFFFF_FFFF, 1'b0};
      vecs[9]  = '{6'h2A, 16'h8000, 16'h7FFF, 32'h0000_0001, 1'b0};
      vecs[10] = '{6'h21, 16'h0001, 16'h0001, 32'h0000_0000, 1'b1};

      // Reset state and first addi.
      clr_img();
      put(32'h100, f_addi(5'd1, 5'd0, 16'd5));
      do_reset();
      chk("rst_addr", {32'b0, mem_addr}, 64'h100);
      chk("rst_req", {63'b0, mem_req}, 64'd1);
      chk("rst_we", {63'b0, mem_we}, 64'd0);
      chk("rst_pc", {32'b0, pc}, 64'h100);
      chk("rst_trap", {63'b0, trap}, 64'd0);
      chk("rst_instret", {32'b0, instret}, 64'd0);
      step(3);
      chk("addi_c3_reg", {32'b0, dut.u_rf.r_regs[1]}, 64'd0);
      step(1);
      chk("addi_c4_reg", {32'b0, dut.u_rf.r_regs[1]}, 64'd5);
      chk("addi_pc", {32'b0, pc}, 64'h104);
      chk("addi_instret", {32'b0, instret}, 64'd1);

      // ALU table: addi $1,a ; addi $2,b ; rtype $3,$1,$2.
      for (int i = 0; i < 11; i++) begin
         clr_img();
         put(32'h100, f_addi(5'd1, 5'd0, vecs[i].a));
         put(32'h104, f_addi(5'd2, 5'd0, vecs[i].b));
         put(32'h108, f_r(5'd3, 5'd1, 5'd2, vecs[i].funct));
         do_reset();
         step(12);
         chk($sformatf("alu%0d_res", i), {32'b0, dut.u_rf.r_regs[3]}, {32'b0, vecs[i].res});
         chk($sformatf("alu%0d_trap", i), {63'b0, trap}, {63'b0, vecs[i].tr});
         chk($sformatf("alu%0d_instret", i), {32'b0, instret}, vecs[i].tr ? 64'd2 : 64'd3);
      end

      // sw/lw with 3 wait cycles on every request.
      clr_img();
      put(32'h100, f_addi(5'd1, 5'd0, 16'hFFFF));
      put(32'h104, f_mem(6'h2B, 5'd1, 5'd0, 16'd8));
      put(32'h108, f_mem(6'h23, 5'd5, 5'd0, 16'd8));
      wait_n = 3;
      do_reset();
      stab_en = 1'b1;
      step(40);
      stab_en = 1'b0;
      chk("sw_we", {63'b0, getx(2).we}, 64'd1);
      chk("sw_addr", {32'b0, getx(2).addr}, 64'd8);
      chk("sw_wdata", {32'b0, getx(2).wdata}, 64'hFFFF_FFFF);
      chk("lw_req", {31'b0, getx(4).we, getx(4).addr}, 64'd8);
      chk("sw_cycles", 64'(getx(3).start - getx(1).hs), 64'd7);
      chk("lw_cycles", 64'(getx(5).start - getx(3).hs), 64'd8);
      chk("lw_reg5", {32'b0, dut.u_rf.r_regs[5]}, 64'hFFFF_FFFF);
      chk("sw_mem", {32'b0, mem[2]}, 64'hFFFF_FFFF);
      wait_n = 0;

      // beq not taken, j to 0x10, j 0x40 back to 0x100.
      clr_img();
      put(32'h100, f_addi(5'd1, 5'd0, 16'd1));
      put(32'h104, f_j(26'd4));
      put(32'h010, f_beq(5'd0, 5'd1, 16'd5));
      put(32'h014, f_j(26'h40));
      do_reset();
      step(16);
      chk("j_target", {32'b0, getx(2).addr}, 64'h10);
      chk("beq_nt_target", {32'b0, getx(3).addr}, 64'h14);
      chk("j40_target", {32'b0, getx(4).addr}, 64'h100);
      chk("j_cycles", 64'(getx(2).start - getx(1).hs), 64'd3);
      chk("beq_cycles", 64'(getx(3).start - getx(2).hs), 64'd3);
      chk("br_instret", {32'b0, instret}, 64'd4);

      // beq taken with imm=-1 at 0x10: tight loop.
      clr_img();
      put(32'h100, f_j(26'd4));
      put(32'h010, f_beq(5'd0, 5'd0, 16'hFFFF));
      do_reset();
      step(10);
      chk("beq_t_1", {32'b0, getx(2).addr}, 64'h10);
      chk("beq_t_2", {32'b0, getx(3).addr}, 64'h10);
      chk("beq_t_instret", {32'b0, instret}, 64'd3);

      // Unaligned lw traps without a data request, and stays trapped.
      clr_img();
      put(32'h100, f_mem(6'h23, 5'd1, 5'd0, 16'd2));
      do_reset();
      step(2);
      chk("unal_trap_early", {63'b0, trap}, 64'd0);
      step(1);
      chk("unal_trap", {63'b0, trap}, 64'd1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (trap !== 1'b1 || mem_req !== 1'b0) bad++;
      end
      chk("trap_sticky", 64'(bad), 64'd0);
      chk("unal_no_req", 64'(log_q.size()), 64'd1);
      chk("unal_instret", {32'b0, instret}, 64'd0);
      chk("unal_pc", {32'b0, pc}, 64'h104);

      // Illegal opcode 6'h3F.
      clr_img();
      put(32'h100, 32'hFC00_0000);
      do_reset();
      chk("rst_clears_trap", {63'b0, trap}, 64'd0);
      step(1);
      chk("ill_trap_c1", {63'b0, trap}, 64'd0);
      step(1);
      chk("ill_trap_c2", {63'b0, trap}, 64'd1);
      chk("ill_pc", {32'b0, pc}, 64'h104);

      // Reset during a long stalled fetch.
      clr_img();
      put(32'h100, f_addi(5'd1, 5'd0, 16'd5));
      do_reset();
      step(4);
      wait_n = 100;
      step(5);
      chk("stall_addr", {32'b0, mem_addr}, 64'h104);
      chk("stall_req", {63'b0, mem_req}, 64'd1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("mid_state", 64'(dut.r_state), 64'(ST_FETCH));
      chk("mid_pc", {32'b0, pc}, 64'h100);
      chk("mid_addr", {32'b0, mem_addr}, 64'h100);
      chk("mid_trap", {63'b0, trap}, 64'd0);
      chk("mid_instret", {32'b0, instret}, 64'd0);
      chk("mid_reg1", {32'b0, dut.u_rf.r_regs[1]}, 64'd0);
      wait_n = 0;

      // Reset coinciding with a ready fetch handshake: nothing captured.
      do_reset();
      step(4);
      chk("coinc_ready", {63'b0, mem_ready}, 64'd1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("coinc_pc", {32'b0, pc}, 64'h100);
      chk("coinc_state", 64'(dut.r_state), 64'(ST_FETCH));
      chk("coinc_instret", {32'b0, instret}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
